mem_access_unit: RTL

- Memory-stage sequencer that sits between the execute/memory pipeline register and the four byte-wide BRAM banks.
- Accepts one load/store request at a time and derives the byte enables from the access size.
- Drives the rotated per-bank address, write data and write enables; waits out the BRAM read latency; re-assembles and extends load data.
- Hands the result to the memory/writeback pipeline register over a valid/ready handshake.

---
 rtl/mem_access_unit_if.sv | 42 ++++
 rtl/mem_access_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/mem_access_unit_if.sv
// Request, bank and response signals of the memory-stage sequencer.
// slave is the sequencer side; master is the pipeline/BRAM side.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 19
);
    localparam int BW = ADDR_WIDTH - 2;

    logic            req_valid;
    logic            req_ready;
    logic [31:0]     req_address;
    logic [31:0]     req_data;
    logic [4:0]      req_code;
    logic [4:0]      req_rd;
    logic [3:0]      bank_en;
    logic [3:0]      bank_we;
    logic [4*BW-1:0] bank_addr;
    logic [31:0]     bank_wdata;
    logic [31:0]     bank_rdata;
    logic            resp_valid;
    logic            resp_ready;
    logic [31:0]     resp_data;
    logic [4:0]      resp_rd;
    logic            resp_error;

    modport slave (
        input  req_valid, req_address, req_data, req_code, req_rd,
        output req_ready,
        output bank_en, bank_we, bank_addr, bank_wdata,
        input  bank_rdata,
        output resp_valid, resp_data, resp_rd, resp_error,
        input  resp_ready
    );

    modport master (
        output req_valid, req_address, req_data, req_code, req_rd,
        input  req_ready,
        input  bank_en, bank_we, bank_addr, bank_wdata,
        output bank_rdata,
        input  resp_valid, resp_data, resp_rd, resp_error,
        output resp_ready
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage sequencer: one load/store at a time over four
// byte-wide big-endian BRAM banks.
module mem_access_unit #(
    parameter int ADDR_WIDTH   = 19,
    parameter int READ_LATENCY = 1
) (
    input logic              clk,
    input logic              rst_n,
    mem_access_unit_if.slave bus
);
    localparam int BW = ADDR_WIDTH - 2;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WAIT   = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;
    localparam logic [1:0] LAST   = 2'(READ_LATENCY - 1);

    logic [1:0]  state;
    logic [1:0]  lat_cnt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [3:0]  code_q;
    logic [31:0] resp_data_q;
    logic [4:0]  resp_rd_q;
    logic        resp_err_q;

    logic [1:0]      size;
    logic [1:0]      nb_m1;
    logic            store;
    logic            err;
    logic            active;
    logic [ADDR_WIDTH:0] last_byte;
    logic [3:0]      en_c;
    logic [4*BW-1:0] addr_c;
    logic [31:0]     wdata_c;
    logic [31:0]     asm_c;
    logic [31:0]     ext_c;
    logic [2:0]      pos;
    logic [31:0]     sh;
    int              bi;

    assign size  = code_q[2:1];
    assign store = code_q[0];

    always_comb begin
        nb_m1 = 2'd3;
        unique case (1'b1)
            size == 2'b00: nb_m1 = 2'd0;
            size == 2'b01: nb_m1 = 2'd1;
            default:       nb_m1 = 2'd3;
        endcase
    end

    // Carry out of the low ADDR_WIDTH bits means the access runs off the top.
    assign last_byte = {1'b0, addr_q[ADDR_WIDTH-1:0]}
                     + {{(ADDR_WIDTH-1){1'b0}}, nb_m1};
    assign err = (size == 2'b11)
              || ((addr_q >> ADDR_WIDTH) != 32'd0)
              || last_byte[ADDR_WIDTH];

    // Byte j of the access sits at offset addr+j, in bank 3-offset.
    always_comb begin
        en_c    = '0;
        addr_c  = {4{addr_q[ADDR_WIDTH-1:2]}};
        wdata_c = '0;
        asm_c   = '0;
        pos     = '0;
        sh      = '0;
        bi      = 0;
        for (int j = 0; j < 4; j++) begin
            pos = {1'b0, addr_q[1:0]} + 3'(j);
            bi  = 3 - int'(pos[1:0]);
            sh  = data_q >> {nb_m1 - 2'(j), 3'b000};
            if (2'(j) <= nb_m1) begin
                en_c[bi]                = 1'b1;
                addr_c[bi*BW +: BW]     = addr_q[ADDR_WIDTH-1:2] + BW'(pos[2]);
                wdata_c[bi*8 +: 8]      = sh[7:0];
                asm_c = {asm_c[23:0], bus.bank_rdata[bi*8 +: 8]};
            end
        end
    end

    always_comb begin
        ext_c = asm_c;
        unique case (1'b1)
            size == 2'b00: ext_c = {{24{~code_q[3] & asm_c[7]}}, asm_c[7:0]};
            size == 2'b01: ext_c = {{16{~code_q[3] & asm_c[15]}}, asm_c[15:0]};
            default:       ext_c = asm_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            code_q      <= '0;
            resp_data_q <= '0;
            resp_rd_q   <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (bus.req_valid) begin
                    addr_q      <= bus.req_address;
                    data_q      <= bus.req_data;
                    code_q      <= bus.req_code[3:0];
                    resp_rd_q   <= bus.req_rd;
                    resp_data_q <= '0;
                    resp_err_q  <= 1'b0;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    resp_err_q <= err;
                    lat_cnt    <= '0;
                    state      <= (err || store) ? RESP : WAIT;
                end
                WAIT: begin
                    if (lat_cnt == LAST) begin
                        resp_data_q <= ext_c;
                        state       <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                default: if (bus.resp_ready) state <= IDLE;
            endcase
        end
    end

    assign active         = (state == ACCESS) && !err;
    assign bus.req_ready  = (state == IDLE);
    assign bus.bank_en    = active ? en_c : 4'b0;
    assign bus.bank_we    = (active && store) ? en_c : 4'b0;
    assign bus.bank_wdata = (active && store) ? wdata_c : 32'b0;
    assign bus.bank_addr  = addr_c;
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_rd    = resp_rd_q;
    assign bus.resp_error = resp_err_q;
endmodule
